// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types, defaults and helpers for the UART RX sampler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    localparam int c_DATA_BITS_DEFAULT   = 8;
    localparam int c_OVERSAMPLE_DEFAULT  = 16;
    localparam int c_SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler_if.sv
// ============================================================================
// Module      : uart_rx_sampler_if
// Description : Received-word handshake and status bundle (UART_RX_PARITY_EN
//               adds parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
`ifdef UART_RX_PARITY_EN
        ,
        output parity_err
`endif
    );

    modport slave (
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
`ifdef UART_RX_PARITY_EN
        ,
        input  parity_err
`endif
    );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : rx line synchroniser and dds_clk rising-edge tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_dds_clk,
    input  logic i_rx,
    output logic o_tick,
    output logic o_rx_s
);

    logic                   r_dds_clk_q;
    logic [SYNC_STAGES-1:0] r_sync;

    // dds_clk already lives in the clk domain, so only rx needs the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dds_clk_q <= 1'b0;
            r_sync      <= '1;
        end else begin
            r_dds_clk_q <= i_dds_clk;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_tick = i_dds_clk & ~r_dds_clk_q;
    assign o_rx_s = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : UART receive front end: start detection, mid-cell majority
//               vote, frame assembly and valid/ready output. Optional parity
//               checking is built when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = c_DATA_BITS_DEFAULT,
    parameter int OVERSAMPLE  = c_OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dds_clk,
    input  logic              rx,
    uart_rx_sampler_if.master rx_if
);

    localparam int c_SW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS);
    localparam int c_M  = OVERSAMPLE / 2;

    localparam logic [c_SW-1:0] c_SCNT_LAST    = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_SW-1:0] c_SCNT_VOTE_LO = c_SW'(c_M - 1);
    localparam logic [c_SW-1:0] c_SCNT_VOTE_HI = c_SW'(c_M + 1);
    localparam logic [c_BW-1:0] c_BCNT_LAST    = c_BW'(DATA_BITS - 1);

    logic                 w_tick;
    logic                 w_rx_s;

    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [c_SW-1:0]      r_scnt;
    logic [c_SW-1:0]      w_scnt_inc;
    logic [c_BW-1:0]      r_bcnt;
    logic [2:0]           r_vote;
    logic [2:0]           w_vote;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_scnt_last;
    logic                 w_bcnt_last;
    logic                 w_vote_en;
    logic                 w_bit;
    logic                 w_busy;
    logic                 w_stop_dec;
    logic                 w_load;
    logic                 w_overrun;
    logic                 w_frame_err;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_dds_clk (dds_clk),
        .i_rx      (rx),
        .o_tick    (w_tick),
        .o_rx_s    (w_rx_s)
    );

    assign w_scnt_last = (r_scnt == c_SCNT_LAST);
    assign w_bcnt_last = (r_bcnt == c_BCNT_LAST);
    assign w_scnt_inc  = w_scnt_last ? '0 : r_scnt + 1'b1;
    assign w_vote_en   = w_tick && (r_state != IDLE) &&
                         (r_scnt >= c_SCNT_VOTE_LO) && (r_scnt <= c_SCNT_VOTE_HI);
    // The STOP decision lands on the third vote tick, so vote on the updated set
    assign w_vote      = w_vote_en ? {r_vote[1:0], w_rx_s} : r_vote;
    assign w_bit       = maj3(w_vote);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next = START;
                    end
                end
                START: begin
                    if (w_scnt_last) begin
                        w_state_next = w_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_scnt_last && w_bcnt_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_scnt_last) begin
                        w_state_next = STOP;
                    end
                end
`endif
                STOP: begin
                    if (r_scnt == c_SCNT_VOTE_HI) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_busy      = 1'b0;
        w_stop_dec  = 1'b0;
        w_load      = 1'b0;
        w_overrun   = 1'b0;
        w_frame_err = 1'b0;

        w_busy      = (r_state != IDLE);
        w_stop_dec  = w_tick && (r_state == STOP) && (r_scnt == c_SCNT_VOTE_HI);
        // A same-cycle accept frees the holding register, so the load wins
        w_load      = w_stop_dec && w_bit && (!r_valid || rx_if.rx_ready);
        w_overrun   = w_stop_dec && w_bit && r_valid && !rx_if.rx_ready;
        w_frame_err = w_stop_dec && !w_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scnt      <= '0;
            r_bcnt      <= '0;
            r_vote      <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end

            if (w_tick) begin
                r_vote <= w_vote;
                case (r_state)
                    IDLE: begin
                        r_scnt <= '0;
                        r_bcnt <= '0;
                    end
                    STOP: begin
                        r_scnt <= w_stop_dec ? '0 : w_scnt_inc;
                    end
                    default: begin
                        r_scnt <= w_scnt_inc;
                    end
                endcase

                if ((r_state == DATA) && w_scnt_last) begin
                    r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bcnt  <= w_bcnt_last ? '0 : r_bcnt + 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_tick && (r_state == PARITY) && w_scnt_last) begin
                r_par <= w_bit;
            end
            r_parity_err <= w_stop_dec && ((^r_shift ^ r_par) != PARITY_ODD);
        end
    end

    assign rx_if.parity_err = r_parity_err;
`endif

    assign rx_if.rx_data   = r_data;
    assign rx_if.rx_valid  = r_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.overrun   = r_overrun;
    assign rx_if.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
// ============================================================================
// Module      : tb_uart_rx_sampler
// Description : Directed self-checking bench for uart_rx_sampler; parity cases
//               are included when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_sampler;

    logic clk = 1'b0;
    logic rst;
    logic dds_clk;
    logic rx;

    int n_checks = 0;
    int n_fail   = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_perr  = 0;
    int s_valid;
    int s_ferr;
    int s_ovr;
    int s_perr;
    logic [7:0] last_data = 8'h00;

    uart_rx_sampler_if #(.DATA_BITS(8)) u_if ();

    uart_rx_sampler #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD  (1'b0)
`endif
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .dds_clk (dds_clk),
        .rx      (rx),
        .rx_if   (u_if)
    );

    always #5 clk = ~clk;

    // dds_clk period is 4 clk, so one tick every 4 clk and 64 clk per bit
    initial begin
        dds_clk = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            dds_clk = ~dds_clk;
        end
    end

    always @(negedge clk) begin
        if (u_if.rx_valid === 1'b1) begin
            n_valid++;
            last_data = u_if.rx_data;
        end
        if (u_if.frame_err === 1'b1) n_ferr++;
        if (u_if.overrun === 1'b1)   n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (u_if.parity_err === 1'b1) n_perr++;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        s_valid = n_valid;
        s_ferr  = n_ferr;
        s_ovr   = n_ovr;
        s_perr  = n_perr;
    endtask

    // Noise flips rx for the posedges that feed only the scnt=M vote
    task automatic send_bit(input logic b, input bit noise);
        rx = b;
        if (noise) begin
            repeat (36) @(negedge clk);
            rx = ~b;
            repeat (4) @(negedge clk);
            rx = b;
            repeat (24) @(negedge clk);
        end else begin
            repeat (64) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input bit with_par, input logic par_b, input bit noise);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], noise);
        if (with_par) send_bit(par_b, 1'b0);
        send_bit(stop_b, 1'b0);
        rx = 1'b1;
        repeat (128) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        rx            = 1'b1;
        u_if.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_valid", 32'(u_if.rx_valid),  32'h0);
        check_eq("reset_data",  32'(u_if.rx_data),   32'h0);
        check_eq("reset_busy",  32'(u_if.busy),      32'h0);
        check_eq("reset_ferr",  32'(u_if.frame_err), 32'h0);
        check_eq("reset_ovr",   32'(u_if.overrun),   32'h0);
        rst = 1'b0;
        repeat (64) @(negedge clk);

        // Good frame
        mark();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("a5_data",   32'(last_data),     32'hA5);
        check_eq("a5_vcyc",   n_valid - s_valid,  32'd1);
        check_eq("a5_ferr",   n_ferr - s_ferr,    32'd0);
        check_eq("a5_ovr",    n_ovr - s_ovr,      32'd0);
        check_eq("a5_busy",   32'(u_if.busy),     32'h0);

        // Short glitch must be rejected as a false start
        mark();
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        check_eq("glitch_busy_hi", 32'(u_if.busy), 32'h1);
        repeat (64) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(u_if.busy),    32'h0);
        check_eq("glitch_valid",   n_valid - s_valid, 32'd0);
        check_eq("glitch_ferr",    n_ferr - s_ferr,   32'd0);
        repeat (64) @(negedge clk);

        // Bad stop bit, then recovery
        mark();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("3c_ferr",  n_ferr - s_ferr,   32'd1);
        check_eq("3c_valid", n_valid - s_valid, 32'd0);
        mark();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("5a_data",  32'(last_data),    32'h5A);
        check_eq("5a_vcyc",  n_valid - s_valid, 32'd1);
        check_eq("5a_ferr",  n_ferr - s_ferr,   32'd0);

        // Overrun with consumer stalled
        u_if.rx_ready = 1'b0;
        mark();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ovr_data",  32'(u_if.rx_data),  32'h11);
        check_eq("ovr_valid", 32'(u_if.rx_valid), 32'h1);
        check_eq("ovr_count", n_ovr - s_ovr,      32'd1);
        check_eq("ovr_ferr",  n_ferr - s_ferr,    32'd0);
        u_if.rx_ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_clear", 32'(u_if.rx_valid), 32'h0);
        repeat (16) @(negedge clk);

        // Single-sample noise on every data bit
        mark();
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("noise_data", 32'(last_data),    32'hF0);
        check_eq("noise_vcyc", n_valid - s_valid, 32'd1);

        // Reset mid-DATA with a word pending
        u_if.rx_ready = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pend_data", 32'(u_if.rx_data), 32'h66);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        check_eq("mid_busy", 32'(u_if.busy), 32'h1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 32'(u_if.rx_valid),  32'h0);
        check_eq("rst_data",  32'(u_if.rx_data),   32'h0);
        check_eq("rst_busy",  32'(u_if.busy),      32'h0);
        check_eq("rst_ferr",  32'(u_if.frame_err), 32'h0);
        u_if.rx_ready = 1'b1;
        repeat (768) @(negedge clk);
        mark();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("81_data", 32'(last_data),    32'h81);
        check_eq("81_vcyc", n_valid - s_valid, 32'd1);
        check_eq("81_ferr", n_ferr - s_ferr,   32'd0);

`ifdef UART_RX_PARITY_EN
        mark();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("par_ok_data", 32'(last_data),    32'h07);
        check_eq("par_ok_perr", n_perr - s_perr,   32'd0);
        mark();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("par_bad_data", 32'(last_data),    32'h07);
        check_eq("par_bad_vcyc", n_valid - s_valid, 32'd1);
        check_eq("par_bad_perr", n_perr - s_perr,   32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
